iq_fifo_bridge: RTL and testbench

IQ_FIFO_BRIDGE -- requirements
Module: iq_fifo_bridge

---
 rtl/iq_fifo_pkg.sv | 18 +
 rtl/sync_rise.sv | 28 ++
 rtl/iq_fifo_bridge.sv | 153 +++++++++++++++
 tb/tb_iq_fifo_bridge.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/iq_fifo_pkg.sv
// Shared types and defaults for the IQ FIFO bridge toward the STM32 nibble interface.
// Optional feature macro used by the top: IQ_FIFO_DROP_COUNT_EN.
package iq_fifo_pkg;

    localparam int unsigned SAMPLE_W_DEF = 16;
    localparam int unsigned DEPTH_DEF    = 8;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic signed [SAMPLE_W_DEF-1:0] i;
        logic signed [SAMPLE_W_DEF-1:0] q;
    } iq_pair_t;

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchroniser for an asynchronous line plus a registered rising-edge detector.
// A raw rise shows up on rise as a one-cycle pulse three clk edges later.
module sync_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
            rise   <= 1'b0;
        end else begin
            meta   <= din;
            sync   <= meta;
            sync_d <= sync;
            rise   <= sync & ~sync_d;
        end
    end

endmodule

// File: rtl/iq_fifo_bridge.sv
// Buffers decimated I/Q pairs and releases one pair per STM32 frame-start (DATA_SYNC rise).
// Define IQ_FIFO_DROP_COUNT_EN to build the saturating dropped-sample counter.
module iq_fifo_bridge
    import iq_fifo_pkg::*;
#(
    parameter int unsigned SAMPLE_W    = SAMPLE_W_DEF,
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned PRIME_LEVEL = DEPTH / 2
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic [SAMPLE_W-1:0]      in_I,
    input  logic [SAMPLE_W-1:0]      in_Q,
    input  logic                     in_valid,
    input  logic                     DATA_SYNC,
    input  logic                     clear_flags,
    output logic [SAMPLE_W-1:0]      I,
    output logic [SAMPLE_W-1:0]      Q,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     underflow,
    output logic [7:0]               drop_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [SAMPLE_W-1:0] i;
        logic [SAMPLE_W-1:0] q;
    } pair_t;

    // Reset asserts asynchronously, releases two clk_in edges after rst_n rises
    logic [1:0] rst_pipe;
    logic       rst_int_n;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_int_n = rst_pipe[1];

    logic pop_req;

    sync_rise u_sync_rise (
        .clk   (clk_in),
        .rst_n (rst_int_n),
        .din   (DATA_SYNC),
        .rise  (pop_req)
    );

    pair_t            mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LVL_W-1:0] level;
    state_t           state;
    state_t           state_next;
    logic             pop_c;
    logic             unf_c;
    logic             wr_c;
    logic             ovf_c;

    always_ff @(posedge clk_in or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (level >= LVL_W'(PRIME_LEVEL)) state_next = RUN;
            RUN:     if (pop_req && (level == '0)) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // A pop frees a slot, so a write into a full FIFO on the same edge is still accepted
    always_comb begin
        pop_c = 1'b0;
        unf_c = 1'b0;
        wr_c  = 1'b0;
        ovf_c = 1'b0;
        if ((state == RUN) && pop_req) begin
            if (level != '0) pop_c = 1'b1;
            else             unf_c = 1'b1;
        end
        if (in_valid) begin
            if ((level != LVL_W'(DEPTH)) || pop_c) wr_c  = 1'b1;
            else                                   ovf_c = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_c) begin
            mem[wr_ptr] <= '{i: in_I, q: in_Q};
        end
    end

    always_ff @(posedge clk_in or negedge rst_int_n) begin
        if (!rst_int_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            I         <= '0;
            Q         <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                I      <= mem[rd_ptr].i;
                Q      <= mem[rd_ptr].q;
            end
            case ({wr_c, pop_c})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            // A new event outranks a coincident clear
            if (ovf_c)            overflow  <= 1'b1;
            else if (clear_flags) overflow  <= 1'b0;
            if (unf_c)            underflow <= 1'b1;
            else if (clear_flags) underflow <= 1'b0;
        end
    end

    assign fifo_level = level;

`ifdef IQ_FIFO_DROP_COUNT_EN
    always_ff @(posedge clk_in or negedge rst_int_n) begin
        if (!rst_int_n) begin
            drop_count <= '0;
        end else if (ovf_c) begin
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end else if (clear_flags) begin
            drop_count <= '0;
        end
    end
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_iq_fifo_bridge.sv
// Self-checking bench for iq_fifo_bridge: directed scenarios then random traffic,
// all compared against a queue-based reference model.
module tb_iq_fifo_bridge;
    import iq_fifo_pkg::*;

    localparam int unsigned SW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PRIME = DEPTH / 2;
`ifdef IQ_FIFO_DROP_COUNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic          clk_in      = 1'b0;
    logic          rst_n       = 1'b1;
    logic [SW-1:0] in_I        = '0;
    logic [SW-1:0] in_Q        = '0;
    logic          in_valid    = 1'b0;
    logic          DATA_SYNC   = 1'b0;
    logic          clear_flags = 1'b0;
    logic [SW-1:0] I;
    logic [SW-1:0] Q;
    logic [3:0]    fifo_level;
    logic          overflow;
    logic          underflow;
    logic [7:0]    drop_count;

    iq_fifo_bridge #(.SAMPLE_W(SW), .DEPTH(DEPTH), .PRIME_LEVEL(PRIME)) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .in_I        (in_I),
        .in_Q        (in_Q),
        .in_valid    (in_valid),
        .DATA_SYNC   (DATA_SYNC),
        .clear_flags (clear_flags),
        .I           (I),
        .Q           (Q),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .underflow   (underflow),
        .drop_count  (drop_count)
    );

    always #5 clk_in = ~clk_in;

    // Reference model state
    iq_pair_t      mq[$];
    bit            rr[$];
    bit            ds_prev;
    bit            m_run;
    logic [SW-1:0] m_I;
    logic [SW-1:0] m_Q;
    bit            m_ovf;
    bit            m_unf;
    int            m_drop;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        rr = '{1'b0, 1'b0, 1'b0};
        ds_prev = 1'b0;
        m_run = 1'b0;
        m_I = '0;
        m_Q = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_drop = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_level"}, 32'(fifo_level), 32'(mq.size()));
        chk({tag, "_I"}, 32'(I), 32'(m_I));
        chk({tag, "_Q"}, 32'(Q), 32'(m_Q));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, "_unf"}, 32'(underflow), 32'(m_unf));
        chk({tag, "_drop"}, 32'(drop_count), 32'(m_drop));
        chk({tag, "_run"}, 32'(dut.state == RUN), 32'(m_run));
    endtask

    // One clock: drive inputs, advance the model by the rules, compare everything
    task automatic step(input string tag, input bit v, input logic [SW-1:0] ii,
                        input logic [SW-1:0] qq, input bit ds, input bit clr);
        bit p, pop_ok, uf, wr_ok, ov;
        int old;
        iq_pair_t e;
        in_valid = v; in_I = ii; in_Q = qq; DATA_SYNC = ds; clear_flags = clr;
        rr.push_back(ds & ~ds_prev);
        ds_prev = ds;
        p = rr.pop_front();
        @(posedge clk_in);
        #1;
        old    = mq.size();
        pop_ok = m_run && p && (old > 0);
        uf     = m_run && p && (old == 0);
        wr_ok  = v && ((old < int'(DEPTH)) || pop_ok);
        ov     = v && !wr_ok;
        if (pop_ok) begin
            e = mq.pop_front();
            m_I = e.i;
            m_Q = e.q;
        end
        if (wr_ok) begin
            e.i = ii;
            e.q = qq;
            mq.push_back(e);
        end
        m_ovf = ov | (m_ovf & ~clr);
        m_unf = uf | (m_unf & ~clr);
        if (DROP_EN) begin
            if (ov) m_drop = (m_drop == 255) ? 255 : m_drop + 1;
            else if (clr) m_drop = 0;
        end
        if (!m_run) m_run = (old >= int'(PRIME));
        else        m_run = !uf;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic write(input string tag, input logic [SW-1:0] ii, input logic [SW-1:0] qq);
        step(tag, 1'b1, ii, qq, 1'b0, 1'b0);
    endtask

    task automatic pulse_pop(input string tag);
        step(tag, 1'b0, '0, '0, 1'b1, 1'b0);
        idle(tag, 3);
    endtask

    // Asserts reset right after an edge, checks the asynchronous clear, holds one cycle
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        chk({tag, "_async_level"}, 32'(fifo_level), 32'd0);
        chk({tag, "_async_I"}, 32'(I), 32'd0);
        chk({tag, "_async_Q"}, 32'(Q), 32'd0);
        chk({tag, "_async_run"}, 32'(dut.state == RUN), 32'd0);
        chk({tag, "_async_flags"}, 32'({overflow, underflow, drop_count}), 32'd0);
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0; DATA_SYNC = 1'b0; clear_flags = 1'b0;
        model_reset();
        idle({tag, "_post"}, 3);
    endtask

    initial begin
        logic [SW-1:0] ev;
        model_reset();
        #1;
        do_reset("rst0");

        // Three samples stay below the prime level, so a frame start is ignored
        for (int k = 0; k < 3; k++) write("s1_wr", SW'($urandom), SW'($urandom));
        pulse_pop("s1_pop");
        idle("s1_idle", 2);
        chk("s1_level", 32'(fifo_level), 32'd3);
        chk("s1_I", 32'(I), 32'd0);
        chk("s1_unf", 32'(underflow), 32'd0);
        chk("s1_run", 32'(dut.state == RUN), 32'd0);

        do_reset("rst1");
        for (int k = 0; k < 4; k++) begin
            ev = SW'(-100 - k);
            write("s2_wr", SW'(100 + k), ev);
        end
        idle("s2_prime", 1);
        for (int k = 0; k < 4; k++) begin
            step("s2_rise", 1'b0, '0, '0, 1'b1, 1'b0);
            idle("s2_wait", 2);
            chk("s2_I_hold", 32'(I), (k == 0) ? 32'd0 : 32'(SW'(99 + k)));
            idle("s2_upd", 1);
            ev = SW'(-100 - k);
            chk("s2_I", 32'(I), 32'(SW'(100 + k)));
            chk("s2_Q", 32'(Q), 32'(ev));
        end

        // Pop while empty in RUN
        pulse_pop("s4_pop");
        ev = SW'(-103);
        chk("s4_I", 32'(I), 32'd103);
        chk("s4_Q", 32'(Q), 32'(ev));
        chk("s4_unf", 32'(underflow), 32'd1);
        chk("s4_run", 32'(dut.state == RUN), 32'd0);
        step("s4_clr", 1'b0, '0, '0, 1'b0, 1'b1);
        chk("s4_unf_clr", 32'(underflow), 32'd0);

        // Overfill by two
        for (int k = 0; k < 10; k++) write("s3_wr", SW'($urandom), SW'($urandom));
        chk("s3_level", 32'(fifo_level), 32'd8);
        chk("s3_ovf", 32'(overflow), 32'd1);
        chk("s3_drop", 32'(drop_count), DROP_EN ? 32'd2 : 32'd0);
        step("s3_clr", 1'b0, '0, '0, 1'b0, 1'b1);
        chk("s3_ovf_clr", 32'(overflow), 32'd0);

        // Write and pop on the same edge while full
        step("s5_rise", 1'b0, '0, '0, 1'b1, 1'b0);
        idle("s5_wait", 2);
        write("s5_wr", SW'($urandom), SW'($urandom));
        chk("s5_level", 32'(fifo_level), 32'd8);
        chk("s5_ovf", 32'(overflow), 32'd0);
        for (int k = 0; k < 8; k++) pulse_pop("s3_drain");
        chk("s3_drained", 32'(fifo_level), 32'd0);

        // Reset with five entries stored
        for (int k = 0; k < 5; k++) write("s6_wr", SW'($urandom), SW'($urandom));
        chk("s6_level", 32'(fifo_level), 32'd5);
        do_reset("s6_rst");

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            step("rnd", ($urandom_range(0, 99) < 45), SW'($urandom), SW'($urandom),
                 ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 4));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
